// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// Latches the winning request, holds it until pmem_resp, then idles one cycle before re-arbitrating.
module pmem_rr_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  icache_mem_resp,
   output logic [LINE_WIDTH-1:0] icache_mem_rdata,
   output logic                  dcache_mem_resp,
   output logic [LINE_WIDTH-1:0] dcache_mem_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   output logic [1:0]            fsm_state_o
);

   // Handshake: a cache holds its request until its mem_resp pulse; pmem_resp completes the
   // latched transaction, and the served cache must drop its request during the RECOVER cycle.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RECOVER = 2'd3
   } state_e;

   state_e                state_q;
   logic                  last_grant_q;   // 0 = I served last, 1 = D served last
   logic                  pmem_read_q;
   logic                  pmem_write_q;
   logic [ADDR_WIDTH-1:0] pmem_address_q;
   logic [LINE_WIDTH-1:0] pmem_wdata_q;

   logic req_i, req_d;
   logic grant_i_d, grant_d_d;

   assign req_i = icache_pmem_read;
   assign req_d = dcache_pmem_read | dcache_pmem_write;

   always_comb begin
      grant_i_d = 1'b0;
      grant_d_d = 1'b0;
      if (req_i && req_d) begin
         grant_i_d = last_grant_q;
         grant_d_d = ~last_grant_q;
      end else begin
         grant_i_d = req_i;
         grant_d_d = req_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         last_grant_q   <= 1'b1;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_i_d) begin
                  pmem_address_q <= icache_pmem_address;
                  pmem_read_q    <= 1'b1;
                  pmem_write_q   <= 1'b0;
                  last_grant_q   <= 1'b0;
                  state_q        <= GRANT_I;
               end else if (grant_d_d) begin
                  // write takes precedence if the D-cache raises both strobes
                  pmem_address_q <= dcache_pmem_address;
                  pmem_wdata_q   <= dcache_pmem_wdata;
                  pmem_write_q   <= dcache_pmem_write;
                  pmem_read_q    <= ~dcache_pmem_write;
                  last_grant_q   <= 1'b1;
                  state_q        <= GRANT_D;
               end
            end
            GRANT_I, GRANT_D: begin
               if (pmem_resp) begin
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
                  state_q      <= RECOVER;
               end
            end
            RECOVER: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign icache_mem_resp  = (state_q == GRANT_I) & pmem_resp;
   assign dcache_mem_resp  = (state_q == GRANT_D) & pmem_resp;
   assign icache_mem_rdata = pmem_rdata;
   assign dcache_mem_rdata = pmem_rdata;

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;
   assign fsm_state_o  = state_q;

endmodule

// File: doc/pmem_rr_arbiter.md
Name: pmem_rr_arbiter

Overview:
Registered, round-robin arbiter that shares the single physical-memory port between the I-cache and D-cache line-fill/write-back interfaces. It sits between both caches' pmem sides and the top-level pmem pins. It latches the winning request, holds it stable to memory until pmem_resp, and routes the response back to the granted cache only. It enforces one idle recovery cycle between transactions so that caches can drop their requests.

Parameters:
ADDR_WIDTH, 16, width of the physical address
LINE_WIDTH, 128, width of one cache line, in bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
icache_pmem_read  in  1  I-cache line read request, held until icache_mem_resp
icache_pmem_address  in  ADDR_WIDTH  I-cache line address
dcache_pmem_read  in  1  D-cache line read request, held until dcache_mem_resp
dcache_pmem_write  in  1  D-cache line write-back request, held until dcache_mem_resp
dcache_pmem_address  in  ADDR_WIDTH  D-cache line address
dcache_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
pmem_resp  in  1  memory completion strobe
pmem_rdata  in  LINE_WIDTH  memory read line, valid with pmem_resp
icache_mem_resp  out  1  completion to the I-cache
icache_mem_rdata  out  LINE_WIDTH  read line to the I-cache
dcache_mem_resp  out  1  completion to the D-cache
dcache_mem_rdata  out  LINE_WIDTH  read line to the D-cache
pmem_read  out  1  memory read strobe, registered
pmem_write  out  1  memory write strobe, registered
pmem_address  out  ADDR_WIDTH  memory address, registered
pmem_wdata  out  LINE_WIDTH  memory write line, registered

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D, RECOVER. A 1-bit last_grant register records the most recently served requester: 0 = I, 1 = D.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, last_grant = 1 (I-cache wins the first tie).
  - pmem_read = pmem_write = 0; pmem_address = 0; pmem_wdata = 0.
  - Both *_mem_resp = 0.
  - Any in-flight memory transaction is abandoned with no response.
- Requests: req_i = icache_pmem_read; req_d = dcache_pmem_read | dcache_pmem_write.
- IDLE:
  - Only one requester active: that requester wins.
  - Both active: the requester not equal to last_grant wins.
  - On a grant, the next edge latches the winner's address into pmem_address. For D, it also latches wdata and sets pmem_write = dcache_pmem_write and pmem_read = ~dcache_pmem_write; write wins if both D strobes are high (illegal input). For I, it sets pmem_read = 1 and pmem_wdata is unchanged. The same edge moves the FSM to GRANT_I or GRANT_D and updates last_grant.
  - Latency: a request sampled in IDLE at edge n appears on pmem at cycle n+1.
- GRANT_x:
  - Registered pmem outputs are held constant; later changes on the requester's inputs are ignored.
  - When pmem_resp = 1: x_mem_resp = 1 combinationally in the same cycle, and x_mem_rdata = pmem_rdata.
  - On the next edge, pmem_read/pmem_write clear to 0 and the FSM moves to RECOVER. pmem_address and pmem_wdata hold their values.
- RECOVER: exactly one cycle, with no grant and no memory strobes; then the FSM returns to IDLE. This lets the served cache deassert its request before re-arbitration.
- Response routing:
  - The non-granted cache's mem_resp is always 0.
  - Both mem_rdata outputs are driven with pmem_rdata at all times; only the resp strobe qualifies them.
- pmem_resp in IDLE or RECOVER is ignored and produces no *_mem_resp.
- Requester deasserting mid-grant: the transaction still runs to pmem_resp, and x_mem_resp still pulses.
- Fairness: with both caches requesting continuously, grants strictly alternate. Maximum wait is one transaction plus the RECOVER cycle.

Test Plan:
- Reset, then I-only read at address 0x1230, memory responds 3 cycles later with rdata = 0xA5…A5 -> pmem_read rises the cycle after the request with pmem_address = 0x1230. icache_mem_resp pulses once with rdata 0xA5…A5, and dcache_mem_resp stays 0. pmem_read is 0 the cycle after resp.
- D write-back at address 0x4440 with wdata = 0xDEAD…BEEF -> pmem_write = 1, pmem_read = 0, and pmem_wdata = 0xDEAD…BEEF, all held stable until pmem_resp. dcache_mem_resp pulses for 1 cycle.
- I and D request in the same cycle after reset -> I is granted first (last_grant reset = D). After RECOVER, D is granted. A third concurrent pair resolves to I again, giving strict alternation over 6 transactions.
- Change dcache_pmem_address from 0x4440 to 0x5550 mid-grant -> pmem_address stays 0x4440 until the transaction completes.
- pmem_resp pulsed while IDLE and while RECOVER -> no *_mem_resp asserts and the state is unchanged.
- Assert reset during GRANT_D before pmem_resp -> pmem_write drops to 0 without waiting for a clock edge, no response is generated, and the FSM is in IDLE on release.
